// File: rtl/vdot_pkg.sv
// Shared definitions for the serial FP16 dot-product block: FSM encoding,
// FP16 constants and small field classifiers used by the arithmetic units.
package vdot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vdot_state_t;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_INF  = 16'h7c00;
    localparam logic [15:0] FP16_QNAN = 16'h7e00;

    // Subnormals are flushed, so a zero exponent field means zero.
    function automatic logic fp16_is_zero(input logic [4:0] e);
        return e == 5'd0;
    endfunction

    function automatic logic fp16_is_inf(input logic [4:0] e, input logic [9:0] m);
        return (e == 5'h1f) && (m == 10'd0);
    endfunction

    function automatic logic fp16_is_nan(input logic [4:0] e, input logic [9:0] m);
        return (e == 5'h1f) && (m != 10'd0);
    endfunction

endpackage

// File: rtl/vdot_serial_n_vadd.sv
// Combinational FP16 adder, round-to-nearest-even with guard/round/sticky,
// subnormals flushed to zero; ovf flags a finite sum that overflowed.
module VADD
    import vdot_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s,
    output logic        ovf
);

    logic        swap;
    logic [15:0] x;
    logic [15:0] y;
    logic [4:0]  d;
    logic [3:0]  sh;
    logic [13:0] x_ext;
    logic [13:0] y_ext;
    logic [27:0] y_wide;
    logic [13:0] y_al;
    logic        sub;
    logic [14:0] sum;
    logic [3:0]  lz;
    logic [13:0] mant;
    logic [6:0]  exp_o;
    logic        inc;
    logic [10:0] frac_rnd;
    logic [6:0]  exp_f;

    // Align the smaller operand, add or subtract, normalise, round, classify.
    always_comb begin
        s      = FP16_ZERO;
        ovf    = 1'b0;
        swap   = b[14:0] > a[14:0];
        x      = swap ? b : a;
        y      = swap ? a : b;
        d      = x[14:10] - y[14:10];
        sh     = (d > 5'd15) ? 4'd15 : d[3:0];
        x_ext  = {1'b1, x[9:0], 3'b000};
        y_ext  = {1'b1, y[9:0], 3'b000};
        y_wide = {y_ext, 14'd0} >> sh;
        y_al   = {y_wide[27:15], y_wide[14] | (|y_wide[13:0])};
        sub    = x[15] ^ y[15];
        sum    = sub ? ({1'b0, x_ext} - {1'b0, y_al}) : ({1'b0, x_ext} + {1'b0, y_al});
        lz     = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (sum[i]) lz = 4'(13 - i);
        end
        if (sum[14]) begin
            mant  = {sum[14:2], sum[1] | sum[0]};
            exp_o = {2'b0, x[14:10]} + 7'd17;
        end else begin
            mant  = sum[13:0] << lz;
            exp_o = {2'b0, x[14:10]} + 7'd16 - {3'b0, lz};
        end
        inc      = mant[2] & (mant[1] | mant[0] | mant[3]);
        frac_rnd = {1'b0, mant[12:3]} + {10'd0, inc};
        exp_f    = exp_o + {6'd0, frac_rnd[10]};

        if (fp16_is_nan(a[14:10], a[9:0]) || fp16_is_nan(b[14:10], b[9:0]) ||
            (fp16_is_inf(a[14:10], a[9:0]) && fp16_is_inf(b[14:10], b[9:0]) && (a[15] != b[15]))) begin
            s = FP16_QNAN;
        end else if (fp16_is_inf(a[14:10], a[9:0])) begin
            s = {a[15], FP16_INF[14:0]};
        end else if (fp16_is_inf(b[14:10], b[9:0])) begin
            s = {b[15], FP16_INF[14:0]};
        end else if (fp16_is_zero(a[14:10]) && fp16_is_zero(b[14:10])) begin
            s = {a[15] & b[15], 15'd0};
        end else if (fp16_is_zero(a[14:10])) begin
            s = b;
        end else if (fp16_is_zero(b[14:10])) begin
            s = a;
        end else if (!mant[13]) begin
            s = FP16_ZERO;
        end else if (exp_f >= 7'd47) begin
            s   = {x[15], FP16_INF[14:0]};
            ovf = 1'b1;
        end else if (exp_f <= 7'd16) begin
            s = {x[15], 15'd0};
        end else begin
            s = {x[15], exp_f[4:0] - 5'd16, frac_rnd[9:0]};
        end
    end

endmodule

// File: rtl/vdot_serial_n_vmult.sv
// Combinational FP16 multiplier, round-to-nearest-even, subnormals flushed
// to zero; ovf flags a finite product that rounded beyond the FP16 range.
module VMULT
    import vdot_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p,
    output logic        ovf
);

    logic        sign;
    logic [21:0] prod;
    logic        norm;
    logic [9:0]  frac;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic [10:0] frac_rnd;
    logic [6:0]  exp_b;

    // Multiply significands, normalise, round, then classify the result.
    always_comb begin
        p        = FP16_ZERO;
        ovf      = 1'b0;
        sign     = a[15] ^ b[15];
        prod     = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        norm     = prod[21];
        if (norm) begin
            frac   = prod[20:11];
            guard  = prod[10];
            sticky = |prod[9:0];
        end else begin
            frac   = prod[19:10];
            guard  = prod[9];
            sticky = |prod[8:0];
        end
        inc      = guard & (sticky | frac[0]);
        frac_rnd = {1'b0, frac} + {10'd0, inc};
        exp_b    = {2'b0, a[14:10]} + {2'b0, b[14:10]} + {6'd0, norm} + {6'd0, frac_rnd[10]};

        if (fp16_is_nan(a[14:10], a[9:0]) || fp16_is_nan(b[14:10], b[9:0]) ||
            (fp16_is_inf(a[14:10], a[9:0]) && fp16_is_zero(b[14:10])) ||
            (fp16_is_zero(a[14:10]) && fp16_is_inf(b[14:10], b[9:0]))) begin
            p = FP16_QNAN;
        end else if (fp16_is_inf(a[14:10], a[9:0]) || fp16_is_inf(b[14:10], b[9:0])) begin
            p = {sign, FP16_INF[14:0]};
        end else if (fp16_is_zero(a[14:10]) || fp16_is_zero(b[14:10])) begin
            p = {sign, 15'd0};
        end else if (exp_b >= 7'd46) begin
            p   = {sign, FP16_INF[14:0]};
            ovf = 1'b1;
        end else if (exp_b <= 7'd15) begin
            p = {sign, 15'd0};
        end else begin
            p = {sign, exp_b[4:0] - 5'd15, frac_rnd[9:0]};
        end
    end

endmodule

// File: rtl/vdot_serial_n.sv
// Serial FP16 dot product: one element pair per cycle through a registered
// multiply stage into an accumulating add stage, with a sticky overflow flag.
module vdot_serial_n
    import vdot_pkg::*;
#(
    parameter  int LEN   = 16,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic        accum,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out,
    output logic        V,
    output logic        busy,
    output logic        done
);

    vdot_state_t      state;
    vdot_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             start_ok;
    logic [15:0]      prod_q;
    logic             prod_ovf_q;
    logic             prod_v;
    logic [15:0]      mul_p;
    logic             mul_ovf;
    logic [15:0]      add_s;
    logic             add_ovf;

    assign accept   = in_valid & in_ready;
    assign start_ok = (state == IDLE) & start;

    VMULT u_mult (
        .a   (A),
        .b   (B),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    VADD u_add (
        .a   (out),
        .b   (prod_q),
        .s   (add_s),
        .ovf (add_ovf)
    );

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode plus the state-derived handshake/status outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == CNT_W'(LEN - 1))) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Count accepted pairs, saturating at LEN; cleared by each new start.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                                cnt <= '0;
        else if (start_ok)                      cnt <= '0;
        else if (accept && cnt != CNT_W'(LEN))  cnt <= cnt + CNT_W'(1);
    end

    // Stage 1: register the product of each accepted pair with its valid flag.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            prod_q     <= FP16_ZERO;
            prod_ovf_q <= 1'b0;
            prod_v     <= 1'b0;
        end else begin
            prod_v <= accept;
            if (accept) begin
                prod_q     <= mul_p;
                prod_ovf_q <= mul_ovf;
            end
        end
    end

    // Stage 2: accumulate valid products; a start without accum clears first.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out <= FP16_ZERO;
            V   <= 1'b0;
        end else if (start_ok && !accum) begin
            out <= FP16_ZERO;
            V   <= 1'b0;
        end else if (prod_v) begin
            out <= add_s;
            V   <= V | prod_ovf_q | add_ovf;
        end
    end

    // Completion pulse, one cycle, raised as the FSM leaves DONE.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) done <= 1'b0;
        else     done <= (state == DONE);
    end

endmodule

// File: tb/tb_vdot_serial_n.sv
// Bench for vdot_serial_n: three instances (LEN 16, 1, 4) share the data
// inputs; each has its own start. Table vectors plus hand sequences.
module tb_vdot_serial_n;

    logic        Clk;
    logic        Rst;
    logic        accum;
    logic        in_valid;
    logic [15:0] A;
    logic [15:0] B;
    logic        start16, start1, start4;
    logic        ready16, ready1, ready4;
    logic [15:0] out16, out1, out4;
    logic        v16, v1, v4;
    logic        busy16, busy1, busy4;
    logic        done16, done1, done4;

    int          sel;
    logic        sel_ready, sel_v, sel_busy, sel_done;
    logic [15:0] sel_out;

    typedef struct {
        int          dut;
        logic [15:0] a;
        logic [15:0] b;
        logic        acc;
        int          stall_at;
        int          stall_len;
        logic [15:0] exp_out;
        logic        exp_v;
        int          exp_edge;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic        v;
        int          edge_n;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   tests_run;
    int   tests_failed;

    vdot_serial_n #(.LEN(16)) dut16 (
        .Clk(Clk), .Rst(Rst), .start(start16), .accum(accum), .A(A), .B(B),
        .in_valid(in_valid), .in_ready(ready16), .out(out16), .V(v16),
        .busy(busy16), .done(done16)
    );

    vdot_serial_n #(.LEN(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .start(start1), .accum(accum), .A(A), .B(B),
        .in_valid(in_valid), .in_ready(ready1), .out(out1), .V(v1),
        .busy(busy1), .done(done1)
    );

    vdot_serial_n #(.LEN(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .start(start4), .accum(accum), .A(A), .B(B),
        .in_valid(in_valid), .in_ready(ready4), .out(out4), .V(v4),
        .busy(busy4), .done(done4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Route the instance under test to a common set of observed signals.
    always_comb begin
        sel_ready = ready16;
        sel_v     = v16;
        sel_busy  = busy16;
        sel_done  = done16;
        sel_out   = out16;
        case (sel)
            1: begin
                sel_ready = ready1; sel_v = v1; sel_busy = busy1;
                sel_done  = done1;  sel_out = out1;
            end
            2: begin
                sel_ready = ready4; sel_v = v4; sel_busy = busy4;
                sel_done  = done4;  sel_out = out4;
            end
            default: ;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic set_start(input int d, input logic val);
        start16 = (d == 0) ? val : 1'b0;
        start1  = (d == 1) ? val : 1'b0;
        start4  = (d == 2) ? val : 1'b0;
    endtask

    // Drive one table vector, queue its expectation, pop and compare on done.
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t  e;
        int    edges;
        bit    seen;
        string tag;
        tag      = $sformatf("vec%0d", idx);
        sel      = v.dut;
        A        = v.a;
        B        = v.b;
        accum    = v.acc;
        in_valid = 1'b1;
        set_start(v.dut, 1'b1);
        e.out    = v.exp_out;
        e.v      = v.exp_v;
        e.edge_n = v.exp_edge;
        sb_q.push_back(e);
        @(posedge Clk); #1;
        set_start(v.dut, 1'b0);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 200) begin
            in_valid = !(((edges + 1) >= v.stall_at) && ((edges + 1) < v.stall_at + v.stall_len));
            @(posedge Clk); #1;
            edges++;
            if (sel_done) seen = 1'b1;
        end
        in_valid = 1'b0;
        checkOutput({tag, " done seen"}, 32'(seen), 32'd1);
        e = sb_q.pop_front();
        checkOutput({tag, " done edge"}, 32'(edges), 32'(e.edge_n));
        checkOutput({tag, " out"}, {16'd0, sel_out}, {16'd0, e.out});
        checkOutput({tag, " V"}, 32'(sel_v), 32'(e.v));
        @(posedge Clk); #1;
        checkOutput({tag, " done pulse width"}, 32'(sel_done), 32'd0);
        checkOutput({tag, " busy after done"}, 32'(sel_busy), 32'd0);
        @(posedge Clk); #1;
        checkOutput({tag, " out held"}, {16'd0, sel_out}, {16'd0, e.out});
    endtask

    initial begin
        int saw_done;
        tests_run    = 0;
        tests_failed = 0;
        Rst      = 1'b1;
        accum    = 1'b0;
        in_valid = 1'b0;
        A        = 16'h0000;
        B        = 16'h0000;
        sel      = 0;
        set_start(0, 1'b0);

        //          dut  A         B         acc  stall@ len  out       V     edge
        vecs[0] = '{0,   16'h3c00, 16'h3c00, 1'b0, 0,    0,   16'h4c00, 1'b0, 18};
        vecs[1] = '{0,   16'h3c00, 16'h3c00, 1'b1, 0,    0,   16'h5000, 1'b0, 18};
        vecs[2] = '{1,   16'h4000, 16'h4200, 1'b0, 0,    0,   16'h4600, 1'b0, 3};
        vecs[3] = '{2,   16'h7bff, 16'h7bff, 1'b0, 0,    0,   16'h7c00, 1'b1, 6};
        vecs[4] = '{2,   16'h3c00, 16'h3c00, 1'b1, 0,    0,   16'h7c00, 1'b1, 6};
        vecs[5] = '{2,   16'h3c00, 16'h3c00, 1'b0, 0,    0,   16'h4400, 1'b0, 6};
        vecs[6] = '{0,   16'h3c00, 16'h3c00, 1'b0, 6,    3,   16'h4c00, 1'b0, 21};

        // Reset state, observed while Rst is still asserted.
        @(posedge Clk); #1;
        checkOutput("reset out", {16'd0, out16}, 32'h0);
        checkOutput("reset V", 32'(v16), 32'd0);
        checkOutput("reset busy", 32'(busy16), 32'd0);
        checkOutput("reset in_ready", 32'(ready16), 32'd0);
        checkOutput("reset done", 32'(done16), 32'd0);
        checkOutput("reset out LEN1", {16'd0, out1}, 32'h0);
        @(posedge Clk); #1;
        Rst = 1'b0;

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

        // LEN=1: in_ready drops after the single acceptance, start held high
        // through RUN/DRAIN is ignored, extra valid pairs are ignored.
        sel = 1; A = 16'h4000; B = 16'h4200; accum = 1'b0; in_valid = 1'b1;
        set_start(1, 1'b1);
        @(posedge Clk); #1;
        checkOutput("len1 in_ready in RUN", 32'(ready1), 32'd1);
        checkOutput("len1 busy in RUN", 32'(busy1), 32'd1);
        @(posedge Clk); #1;
        checkOutput("len1 in_ready after last", 32'(ready1), 32'd0);
        checkOutput("len1 busy in DRAIN", 32'(busy1), 32'd1);
        @(posedge Clk); #1;
        set_start(1, 1'b0);
        checkOutput("len1 out before done", {16'd0, out1}, 32'h4600);
        @(posedge Clk); #1;
        checkOutput("len1 done at edge 3", 32'(done1), 32'd1);
        checkOutput("len1 out at done", {16'd0, out1}, 32'h4600);
        in_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        // Reset in the middle of a LEN=16 run aborts it without a done pulse.
        sel = 0; A = 16'h3c00; B = 16'h3c00; accum = 1'b0; in_valid = 1'b1;
        set_start(0, 1'b1);
        @(posedge Clk); #1;
        set_start(0, 1'b0);
        repeat (8) @(posedge Clk);
        #1;
        Rst = 1'b1;
        #2;
        checkOutput("abort busy", 32'(busy16), 32'd0);
        checkOutput("abort out", {16'd0, out16}, 32'h0);
        checkOutput("abort in_ready", 32'(ready16), 32'd0);
        checkOutput("abort V", 32'(v16), 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge Clk); #1;
            if (done16) saw_done++;
        end
        checkOutput("abort no done", 32'(saw_done), 32'd0);
        checkOutput("abort idle", 32'(busy16), 32'd0);
        applyStimulus(vecs[0], 7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/vdot_serial_n.md
VDOT_SERIAL_N -- requirements
Module: vdot_serial_n

Interface
REQ-001 SHALL have parameter LEN, default 16: number of FP16 element pairs per dot product, legal range 1..1024.
REQ-002 SHALL have derived parameter CNT_W, default $clog2(LEN+1): element-counter width, not overridden by users.
REQ-003 SHALL have port Clk  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  begin a new dot product; sampled only in IDLE.
REQ-006 SHALL have port accum  input  1  sampled with start: 1 = add onto held out, 0 = start from +0.0.
REQ-007 SHALL have port A  input  16  FP16 element of vector A.
REQ-008 SHALL have port B  input  16  FP16 element of vector B.
REQ-009 SHALL have port in_valid  input  1  A/B hold a valid element pair.
REQ-010 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-011 SHALL have port out  output  16  FP16 accumulator/result.
REQ-012 SHALL have port V  output  1  sticky overflow from any multiply or add of the run.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE: IDLE->RUN on start; RUN->DRAIN on acceptance of the LEN-th pair; DRAIN->DONE after one cycle; DONE->IDLE after one cycle.
REQ-016 SHALL accept a pair only when in_valid && in_ready; in_ready = 1 only in RUN.
REQ-017 SHALL register each accepted product (stage 1) with a product-valid flag and add it into out on the following edge (stage 2); out SHALL change only when product-valid = 1, so in_valid gaps stall without altering out.
REQ-018 SHALL, on start with accum = 0, clear out to 16'h0000 and V to 0; with accum = 1, SHALL keep out and V.
REQ-019 SHALL ignore start in RUN, DRAIN and DONE.
REQ-020 SHALL, with in_valid held high, assert done on the (LEN+2)th rising edge after the edge that samples start; each stall cycle adds one.
REQ-021 SHALL hold out and V stable from done until the next accepted start.
REQ-022 SHALL set V when the multiplier or adder overflow flag is high for a valid product; V never self-clears.
REQ-023 SHALL saturate the element counter at LEN; LEN = 1 SHALL go RUN->DRAIN after one acceptance.
REQ-024 SHALL drop in_ready in the cycle following the LEN-th acceptance; extra in_valid pairs SHALL be ignored.

Reset
REQ-025 SHALL, while Rst = 1, force IDLE, out = 16'h0000, V = 0, done = 0, busy = 0, in_ready = 0, counter = 0, product-valid = 0.
REQ-026 SHALL abort any run on Rst mid-operation; no done pulse for the aborted run.

Structure
REQ-027 SHALL place state encoding and FP16 constants (zero 16'h0000) in shared package vdot_pkg.
REQ-028 SHALL instantiate the existing combinational VMULT and VADD units; no other sub-module.

Verification
REQ-029 LEN=16, accum=0, A=B=16'h3c00 every cycle -> done at edge 18, out=16'h4c00, V=0.
REQ-030 Repeat REQ-029 with accum=1 -> out=16'h5000, V=0.
REQ-031 LEN=1, A=16'h4000, B=16'h4200 -> done at edge 3, out=16'h4600.
REQ-032 LEN=4, A=B=16'h7bff -> V=1 by done; V stays 1 until start with accum=0.
REQ-033 LEN=16, in_valid low for 3 cycles mid-run, ones -> done at edge 21, out=16'h4c00.
REQ-034 Rst pulse at cycle 8 of a run -> IDLE, out=16'h0000, no done; new run then gives 16'h4c00.
